// File: rtl/txfifo_72_to_18_sc.sv
// Single-clock transmit FIFO: 72-bit words in, 18-bit lanes out, lane 3 (MSB) first.
// Standard-read (latency 1) output register; flags decode the registered occupancy.
module txfifo_72_to_18_sc #(
    parameter int WR_DEPTH         = 512,
    parameter int PROG_FULL_THRESH = 384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [71:0] din,
    input  logic        wr_en,
    output logic [17:0] dout,
    input  logic        rd_en,
    output logic        empty,
    output logic        full,
    output logic        almost_full,
    output logic        prog_full
);

    localparam int ENTRIES = 4 * WR_DEPTH;
    localparam int AW      = $clog2(ENTRIES);
    localparam int CW      = AW + 1;

    logic [17:0]   mem_q [ENTRIES];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [17:0]   dout_q, dout_d;
    logic          wr_acc, rd_acc;

    assign empty       = (count_q == '0);
    assign full        = (count_q > CW'(ENTRIES - 4));
    assign almost_full = (count_q > CW'(ENTRIES - 8));
    assign prog_full   = (count_q >= CW'(4 * PROG_FULL_THRESH));

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign dout   = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(4);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(4);
            2'b01:   count_d = count_q - CW'(1);
            2'b11:   count_d = count_q + CW'(3);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Write pointer is always a multiple of 4, so the four lanes never straddle the wrap.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[wr_ptr_q + AW'(k)] <= din[18*(3-k) +: 18];
            end
        end
    end

endmodule

// File: tb/tb_txfifo_72_to_18_sc.sv
// Randomized bench for txfifo_72_to_18_sc against a queue-based lane-stream model.
module tb_txfifo_72_to_18_sc;

    localparam int WR_DEPTH = 512;
    localparam int PFT      = 384;
    localparam int ENTRIES  = 4 * WR_DEPTH;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [71:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [17:0] dout;
    logic        empty, full, almost_full, prog_full;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [17:0] mq[$];
    logic [17:0] exp_dout = '0;

    txfifo_72_to_18_sc #(.WR_DEPTH(WR_DEPTH), .PROG_FULL_THRESH(PFT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .wr_en       (wr_en),
        .dout        (dout),
        .rd_en       (rd_en),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .prog_full   (prog_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare dout and all flags with what the lane-stream model implies.
    task automatic chk_state(input string tag);
        logic [3:0] ef;
        ef = {mq.size() == 0, mq.size() > ENTRIES - 4, mq.size() > ENTRIES - 8, mq.size() >= 4 * PFT};
        chk({tag, "/dout"}, 32'(dout), 32'(exp_dout));
        chk({tag, "/flags"}, {28'd0, empty, full, almost_full, prog_full}, {28'd0, ef});
    endtask

    function automatic logic [71:0] rand72();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic cycle(input logic w, input logic r, input logic [71:0] d);
        bit wacc, racc;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        wacc  = w && (mq.size() <= ENTRIES - 4);
        racc  = r && (mq.size() != 0);
        @(posedge clk);
        if (racc) exp_dout = mq.pop_front();
        if (wacc) for (int k = 3; k >= 0; k--) mq.push_back(d[18*k +: 18]);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_state("cyc");
    endtask

    task automatic drain();
        int guard = 0;
        while (mq.size() > 0 && guard < 5000) begin
            cycle(1'b0, 1'b1, '0);
            guard++;
        end
        chk("drain_done", 32'(mq.size()), 32'd0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        mq.delete();
        exp_dout = '0;
        chk({tag, "/dout0"}, 32'(dout), 32'd0);
        chk({tag, "/empty"}, 32'(empty), 32'd1);
        chk({tag, "/full"}, 32'(full), 32'd0);
        chk({tag, "/afull"}, 32'(almost_full), 32'd0);
        chk({tag, "/pfull"}, 32'(prog_full), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [17:0] lanes [4];
        logic [17:0] held;
        logic [71:0] d;
        int          written;
        int          bound;
        bit          w, r;

        lanes[0] = 18'h3AAAA;
        lanes[1] = 18'h2BBBB;
        lanes[2] = 18'h1CCCC;
        lanes[3] = 18'h0DDDD;

        async_reset("rst_init");
        cycle(1'b0, 1'b1, '0);
        chk("rst_rd_dout", 32'(dout), 32'd0);

        // Lane order: lane 3 emerges first.
        cycle(1'b1, 1'b0, {lanes[0], lanes[1], lanes[2], lanes[3]});
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, '0);
            chk("lane", 32'(dout), 32'(lanes[i]));
        end
        chk("lane_empty", 32'(empty), 32'd1);

        // Fill to capacity, overflow attempt, then drain in order.
        for (int i = 0; i < 510; i++) cycle(1'b1, 1'b0, rand72());
        chk("fill510_af", 32'(almost_full), 32'd0);
        chk("fill510_full", 32'(full), 32'd0);
        cycle(1'b1, 1'b0, rand72());
        chk("fill511_af", 32'(almost_full), 32'd1);
        chk("fill511_full", 32'(full), 32'd0);
        cycle(1'b1, 1'b0, rand72());
        chk("fill512_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, rand72());
        chk("fill513_full", 32'(full), 32'd1);
        for (int i = 0; i < ENTRIES - 1; i++) cycle(1'b0, 1'b1, '0);
        chk("fill_last_nonempty", 32'(empty), 32'd0);
        cycle(1'b0, 1'b1, '0);
        chk("fill_drained", 32'(empty), 32'd1);

        // prog_full threshold.
        for (int i = 0; i < PFT - 1; i++) cycle(1'b1, 1'b0, rand72());
        chk("pf383", 32'(prog_full), 32'd0);
        cycle(1'b1, 1'b0, rand72());
        chk("pf384", 32'(prog_full), 32'd1);
        cycle(1'b0, 1'b1, '0);
        chk("pf_read", 32'(prog_full), 32'd0);
        drain();

        // Simultaneous read/write with four entries stored leaves seven.
        cycle(1'b1, 1'b0, rand72());
        cycle(1'b1, 1'b1, rand72());
        chk("simul_nonempty", 32'(empty), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);
        chk("simul_six_read", 32'(empty), 32'd0);
        cycle(1'b0, 1'b1, '0);
        chk("simul_seven_read", 32'(empty), 32'd1);

        // Simultaneous read/write on empty: only the write takes effect.
        held = dout;
        d = rand72();
        cycle(1'b1, 1'b1, d);
        chk("empty_rw_dout", 32'(dout), 32'(held));
        cycle(1'b0, 1'b1, '0);
        chk("empty_rw_first", 32'(dout), 32'(d[71:54]));
        drain();

        // Random interleaving across pointer wraps.
        written = 0;
        bound = 0;
        while ((written < 600 || mq.size() > 0) && bound < 20000) begin
            w = (written < 600) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            if (w && mq.size() <= ENTRIES - 4) written++;
            cycle(w, r, rand72());
            bound++;
        end
        chk("wrap_done", 32'(bound < 20000), 32'd1);

        // Underflow leaves dout and flags untouched.
        held = dout;
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        chk("uflow_dout", 32'(dout), 32'(held));
        chk("uflow_empty", 32'(empty), 32'd1);
        d = rand72();
        cycle(1'b1, 1'b0, d);
        cycle(1'b0, 1'b1, '0);
        chk("uflow_recover", 32'(dout), 32'(d[71:54]));
        drain();

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rand72());
        cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, rand72());
        async_reset("rst_mid");
        cycle(1'b0, 1'b1, '0);
        chk("rst_mid_rd_dout", 32'(dout), 32'd0);
        d = rand72();
        cycle(1'b1, 1'b0, d);
        chk("rst_mid_wr", 32'(empty), 32'd0);
        cycle(1'b0, 1'b1, '0);
        chk("rst_mid_data", 32'(dout), 32'(d[71:54]));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
